// File: rtl/eu_shared_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle unit between NUM_REQ
// issue queues. One operation outstanding at a time; grant is combinational
// in IDLE, result is held in RESP until the owner accepts it, and a hung
// unit is abandoned after TIMEOUT_CYCLES busy cycles.
//
// state | meaning
// IDLE  | no operation outstanding; grant the round-robin winner, if any
// BUSY  | operation launched; waiting for unit_done_i or timeout
// RESP  | result captured; presenting it to owner until rsp_ready_i[owner]
module eu_shared_unit_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_entry_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                unit_start_o,
  output logic [DATA_WIDTH-1:0]               unit_op_o,
  input  logic                                unit_done_i,
  input  logic [RESULT_WIDTH-1:0]             unit_result_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [RESULT_WIDTH-1:0]             rsp_data_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CTR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        owner;
  logic [IDX_W-1:0]        rr_ptr;
  logic [CTR_W-1:0]        busy_ctr;
  logic [RESULT_WIDTH-1:0] rsp_data;
  logic                    timeout;

  logic                    found;
  logic [IDX_W-1:0]        winner;
  logic                    grant;

  // Round-robin search starting at rr_ptr; index arithmetic wraps since NUM_REQ is a power of two
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_i[rr_ptr + IDX_W'(i)]) begin
        found  = 1'b1;
        winner = rr_ptr + IDX_W'(i);
      end
    end
  end

  // Grant is gated by reset so outputs read zero while reset is held
  assign grant = (state == IDLE) && found && !reset;

  // Combinational launch/pop and response presentation
  always_comb begin
    req_ready_o  = '0;
    unit_op_o    = '0;
    rsp_valid_o  = '0;
    if (grant) begin
      req_ready_o = NUM_REQ'(1) << winner;
      unit_op_o   = req_entry_i[winner];
    end
    if (state == RESP) begin
      rsp_valid_o = NUM_REQ'(1) << owner;
    end
  end

  assign unit_start_o = grant;
  assign rsp_data_o   = rsp_data;
  assign busy_o       = (state != IDLE);
  assign timeout_o    = timeout;

  // Sequencer: grant -> busy (done or timeout) -> response handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      busy_ctr <= '0;
      rsp_data <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= winner;
            busy_ctr <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          busy_ctr <= busy_ctr + 1'b1;
          if (unit_done_i) begin
            rsp_data <= unit_result_i;
            state    <= RESP;
          end else if (busy_ctr == CTR_LAST) begin
            timeout <= 1'b1;
            rr_ptr  <= owner + 1'b1;
            state   <= IDLE;
          end
        end
        RESP: begin
          if (rsp_ready_i[owner]) begin
            rr_ptr <= owner + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eu_shared_unit_arbiter.sv
// Bench for eu_shared_unit_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_eu_shared_unit_arbiter;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int RW  = 32;
  localparam int TO  = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_valid_i = '0;
  logic [N-1:0][DW-1:0] req_entry_i = '0;
  logic [N-1:0]        req_ready_o;
  logic                unit_start_o;
  logic [DW-1:0]       unit_op_o;
  logic                unit_done_i = 1'b0;
  logic [RW-1:0]       unit_result_i = '0;
  logic [N-1:0]        rsp_valid_o;
  logic [RW-1:0]       rsp_data_o;
  logic [N-1:0]        rsp_ready_i = '0;
  logic                busy_o;
  logic                timeout_o;

  eu_shared_unit_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_entry_i(req_entry_i), .req_ready_o(req_ready_o),
    .unit_start_o(unit_start_o), .unit_op_o(unit_op_o),
    .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level reference: is an op in flight, is a result waiting,
  // who owns it, where priority starts, how long the unit has been busy.
  bit          m_inflight;
  bit          m_have_rsp;
  int          m_owner;
  int          m_ptr;
  int          m_waited;
  logic [RW-1:0] m_res;
  bit          m_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    m_inflight = 0; m_have_rsp = 0; m_owner = 0; m_ptr = 0;
    m_waited = 0; m_res = '0; m_to = 0;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic [N-1:0] v, input logic d, input logic [RW-1:0] r,
                      input logic [N-1:0] rd);
    int w;
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_op;
    logic [N-1:0]  e_rv;
    @(negedge clk);
    req_valid_i = v;
    for (int k = 0; k < N; k++) req_entry_i[k] = {$urandom, $urandom};
    unit_done_i = d;
    unit_result_i = r;
    rsp_ready_i = rd;
    #1;
    w = (!m_inflight && !m_have_rsp) ? pick(v) : -1;
    e_rdy = (w >= 0) ? (N'(1) << w) : '0;
    e_op  = (w >= 0) ? req_entry_i[w] : '0;
    e_rv  = m_have_rsp ? (N'(1) << m_owner) : '0;
    chk("req_ready", 64'(req_ready_o), 64'(e_rdy));
    chk("unit_start", 64'(unit_start_o), 64'(w >= 0));
    chk("unit_op", unit_op_o, e_op);
    chk("rsp_valid", 64'(rsp_valid_o), 64'(e_rv));
    chk("rsp_data", 64'(rsp_data_o), 64'(m_res));
    chk("busy", 64'(busy_o), 64'(m_inflight || m_have_rsp));
    chk("timeout", 64'(timeout_o), 64'(m_to));
    if (w >= 0) begin
      m_owner = w; m_inflight = 1; m_waited = 0;
    end else if (m_inflight) begin
      m_waited++;
      if (d) begin
        m_res = r; m_inflight = 0; m_have_rsp = 1;
      end else if (m_waited == TO) begin
        m_to = 1; m_inflight = 0; m_ptr = (m_owner + 1) % N;
      end
    end else if (m_have_rsp && rd[m_owner]) begin
      m_have_rsp = 0; m_ptr = (m_owner + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid_i = N'($urandom);
    unit_done_i = 1'b0;
    rsp_ready_i = '0;
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_unit_start", 64'(unit_start_o), 64'd0);
    chk("rst_unit_op", unit_op_o, 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    @(negedge clk);
    req_valid_i = '0;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Requester 2 alone; done three cycles after start with 0xDEAD
    step(4'b0100, 0, '0, '0);
    step(4'b0000, 0, '0, '0);
    step(4'b0000, 0, '0, '0);
    step(4'b0000, 1, 32'hDEAD, '0);
    step(4'b0000, 0, '0, 4'b0100);
    // Priority now starts at 3: requesters 1 and 3 -> 3 first, then 1
    step(4'b1010, 0, '0, '0);
    step(4'b1010, 1, 32'h1111, '0);
    step(4'b1010, 0, '0, 4'b1000);
    step(4'b0010, 0, '0, '0);
    step(4'b0010, 1, 32'h2222, '0);
    step(4'b0000, 0, '0, 4'b0010);

    // All four continuously valid from reset, immediate done/accept -> 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 0, '0, '0);
      step(4'b1111, 1, 32'(i + 32'h100), '0);
      step(4'b1111, 0, '0, 4'b1111);
    end

    // Unit never completes: abort after TO busy cycles, next grant to owner+1
    do_reset();
    step(4'b0001, 0, '0, '0);
    for (int i = 0; i < TO; i++) step(4'b0000, 0, '0, '0);
    step(4'b0011, 0, '0, '0);
    step(4'b0000, 1, 32'h3333, '0);
    step(4'b0000, 0, '0, 4'b0010);
    for (int i = 0; i < 3; i++) step(4'b0000, 0, '0, '0);

    // Owner withholds acceptance for 5 cycles while others keep requesting
    step(4'b0100, 0, '0, '0);
    step(4'b1111, 1, 32'hCAFE_F00D, '0);
    for (int i = 0; i < 5; i++) step(4'b1111, 0, '0, 4'b1011);
    step(4'b1111, 0, '0, 4'b0100);

    // Reset mid-BUSY, stray done afterwards, next grant from index 0
    step(4'b0100, 0, '0, '0);
    step(4'b0000, 0, '0, '0);
    do_reset();
    step(4'b0000, 1, 32'hBAD0, '0);
    step(4'b0000, 0, '0, 4'b1111);
    step(4'b1111, 0, '0, '0);
    step(4'b0000, 1, 32'h4444, '0);
    step(4'b0000, 0, '0, 4'b0001);

    // Random traffic with stray dones, slow acceptance and occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic d;
      if ($urandom_range(0, 249) == 0) do_reset();
      d = m_inflight ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) == 0);
      step(N'($urandom), d, $urandom, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
